spi_master: RTL and testbench

- Single-frame SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
- Drives sclk, mosi and active-low ss toward an SPI slave, and samples miso.
- Sits on the host side of the link, facing the team's SPI slave (spi_top).
- Used for loopback bring-up of the slave and as a reusable host-side controller.
- Local interface: one-cycle start, busy level, one-cycle done pulse, parallel tx_data/rx_data.

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_clk_gen.sv | 40 ++++
 rtl/spi_master.sv | 84 ++++++++
 tb/tb_spi_master.sv | 119 +++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, SPI mode and default frame parameters shared by the
// master and slave sides of the link.
package spi_pkg;
   typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} spi_state_t;
   localparam bit CPOL = 1'b0;
   localparam bit CPHA = 1'b0;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_HALF_DIV = 4;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period divider and sclk edge counter. Emits the strobes
// that the master FSM uses to move sclk and the shift registers.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int HALF_DIV = DEF_HALF_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic rise_tick,
   output logic fall_tick,
   output logic last_edge,
   output logic end_tick
);
   localparam int CW = $clog2(HALF_DIV);
   localparam int EW = $clog2(2*DATA_W+1);
   logic [CW-1:0] div_cnt;
   logic [EW-1:0] edge_cnt;
   logic tick;
   // edge_cnt holds the number of edges already produced, so the edge about
   // to happen is edge_cnt+1; the final count marks the end of the trail phase
   assign tick = run && div_cnt == CW'(HALF_DIV-1);
   assign rise_tick = tick && !edge_cnt[0] && edge_cnt != EW'(2*DATA_W);
   assign fall_tick = tick && edge_cnt[0];
   assign last_edge = tick && edge_cnt == EW'(2*DATA_W-1);
   assign end_tick = tick && edge_cnt == EW'(2*DATA_W);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         div_cnt <= '0;
         edge_cnt <= '0;
      end else if (!run || end_tick) begin
         div_cnt <= '0;
         edge_cnt <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         edge_cnt <= edge_cnt + EW'(tick);
      end
endmodule

// File: rtl/spi_master.sv
// spi_master: single-frame SPI mode 0 master, MSB first, with a start/busy/done
// local handshake.
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int HALF_DIV = DEF_HALF_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              ss
);
   spi_state_t state;
   logic [DATA_W-2:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic rise_tick, fall_tick, last_edge, end_tick;
   spi_clk_gen #(.DATA_W(DATA_W), .HALF_DIV(HALF_DIV)) u_clk_gen (
      .clk(clk),
      .rst(rst),
      .run(state != IDLE),
      .rise_tick(rise_tick),
      .fall_tick(fall_tick),
      .last_edge(last_edge),
      .end_tick(end_tick)
   );
   // tx_sr holds only the bits not yet on mosi; the MSB goes straight to mosi
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         tx_sr <= '0;
         rx_sr <= '0;
         rx_data <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         sclk <= CPOL;
         mosi <= 1'b0;
         ss <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  tx_sr <= tx_data[DATA_W-2:0];
                  mosi <= tx_data[DATA_W-1];
                  ss <= 1'b0;
                  busy <= 1'b1;
                  state <= LEAD;
               end
            LEAD, XFER: begin
               if (rise_tick) begin
                  sclk <= 1'b1;
                  rx_sr <= {rx_sr[DATA_W-2:0], miso};
                  state <= XFER;
               end
               if (fall_tick) begin
                  sclk <= 1'b0;
                  if (last_edge) state <= TRAIL;
                  else begin
                     mosi <= tx_sr[DATA_W-2];
                     tx_sr <= tx_sr << 1;
                  end
               end
            end
            TRAIL:
               if (end_tick) begin
                  ss <= 1'b1;
                  mosi <= 1'b0;
                  busy <= 1'b0;
                  rx_data <= rx_sr;
                  done <= 1'b1;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master (DATA_W=8, HALF_DIV=4) with
// loopback and a scripted slave on miso.
module tb_spi_master;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, loopback = 1'b1, mdrv = 1'b0;
   logic [7:0] tx_data = 8'h00, last_rx = 8'h00;
   logic [7:0] rx_data;
   logic busy, done, sclk, mosi, miso, ss;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;
   assign miso = loopback ? mosi : mdrv;

   spi_master #(.DATA_W(8), .HALF_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy),
      .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One frame sampled after each clk edge T0+j, j=0..68; sw is the slave word on miso
   task automatic frame(input logic [7:0] tx, input logic [7:0] sw, input logic [7:0] exp_rx,
                        input bit hold, input int poke);
      int idx;
      start = 1'b1;
      tx_data = tx;
      mdrv = sw[7];
      for (int j = 0; j <= 68; j++) begin
         @(negedge clk);
         if (!hold && j == 0) start = 1'b0;
         if (j == poke) begin
            start = 1'b1;
            tx_data = 8'h22;
         end
         if (j == poke + 1) start = 1'b0;
         idx = 7 - (j < 64 ? j / 8 : 7);
         mdrv = sw[idx];
         chk($sformatf("ss@%0d", j), ss, j < 68 ? 0 : 1);
         chk($sformatf("busy@%0d", j), busy, j < 68 ? 1 : 0);
         chk($sformatf("done@%0d", j), done, j == 68 ? 1 : 0);
         chk($sformatf("sclk@%0d", j), sclk, (j < 64 && (j / 4) % 2 == 1) ? 1 : 0);
         chk($sformatf("mosi@%0d", j), mosi, j < 68 ? tx[idx] : 1'b0);
         chk($sformatf("rx@%0d", j), rx_data, j == 68 ? exp_rx : last_rx);
      end
      last_rx = exp_rx;
   endtask

   initial begin
      start = 1'b1;
      tx_data = 8'hFF;
      repeat (5) begin
         @(negedge clk);
         chk("rst_ss", ss, 1);
         chk("rst_sclk", sclk, 0);
         chk("rst_mosi", mosi, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_rx", rx_data, 0);
      end
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      frame(8'hA5, 8'h00, 8'hA5, 1'b0, 1000);
      repeat (3) begin
         @(negedge clk);
         chk("idle_ss", ss, 1);
         chk("idle_done", done, 0);
      end
      loopback = 1'b0;
      frame(8'hFF, 8'h3C, 8'h3C, 1'b0, 1000);
      loopback = 1'b1;
      @(negedge clk);
      frame(8'h11, 8'h00, 8'h11, 1'b0, 9);
      repeat (10) begin
         @(negedge clk);
         chk("guard_ss", ss, 1);
         chk("guard_busy", busy, 0);
         chk("guard_done", done, 0);
      end
      frame(8'h81, 8'h00, 8'h81, 1'b1, 1000);
      frame(8'h7E, 8'h00, 8'h7E, 1'b0, 1000);
      @(negedge clk);
      start = 1'b1;
      tx_data = 8'hC3;
      for (int j = 0; j <= 29; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
      end
      chk("pre_rst_sclk", sclk, 1);
      chk("pre_rst_ss", ss, 0);
      rst = 1'b0;
      #1;
      chk("mid_rst_ss", ss, 1);
      chk("mid_rst_sclk", sclk, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_mosi", mosi, 0);
      chk("mid_rst_rx", rx_data, 0);
      repeat (5) begin
         @(negedge clk);
         chk("held_rst_done", done, 0);
         chk("held_rst_ss", ss, 1);
         chk("held_rst_rx", rx_data, 0);
      end
      rst = 1'b1;
      last_rx = 8'h00;
      @(negedge clk);
      frame(8'h5A, 8'h00, 8'h5A, 1'b0, 1000);
      @(negedge clk);
      chk("end_ss", ss, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
